// File: rtl/bfm_ahbl_slave_pkg.sv
// ---------------------------------------------------------------------------
// bfm_ahbl_pkg
// Shared definitions for the AHB-Lite responder BFM:
//   - HTRANS / HSIZE / HRESP encodings
//   - responder FSM state encoding
//   - be_of(): byte-lane enables for a transfer of a given size at a given
//     byte offset (returns 0 for illegal sizes so nothing is written)
// ---------------------------------------------------------------------------
package bfm_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic [3:0] be_of(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: be_of = 4'b0001 << addr;
            HSIZE_HALF: be_of = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be_of = 4'b1111;
            default:    be_of = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bfm_ahbl_slave_if.sv
// ---------------------------------------------------------------------------
// bfm_ahbl_slave_if
// AHB-Lite bus bundle between a master (or bench) and the responder BFM.
//   slave  modport: address/control/write-data in, HREADYOUT/HRESP/HRDATA out
//   master modport: the mirror image
// PROTERR is the responder's sticky protocol-violation sideband.
// HREADY is the bus-level ready coming back from the interconnect mux.
// ---------------------------------------------------------------------------
interface bfm_ahbl_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PROTERR;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK,
        input  HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA, PROTERR
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK,
        output HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA, PROTERR
    );

endinterface

// File: rtl/bfm_ahbl_slave_ram.sv
// ---------------------------------------------------------------------------
// bfm_ahbl_slave_ram
// 2**MEM_AW x 32 storage for the responder BFM.
//   clk   in   write clock
//   we    in   4 byte-lane write enables (lane b = bits [8b+7:8b])
//   idx   in   word index, shared by the write and read port
//   wdata in   write data, lane-aligned
//   rdata out  asynchronous read of mem[idx]
// Contents are not reset.
// ---------------------------------------------------------------------------
module bfm_ahbl_slave_ram #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [MEM_AW-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(2**MEM_AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/bfm_ahbl_slave.sv
// ---------------------------------------------------------------------------
// bfm_ahbl_slave
// AHB-Lite responder BFM: accepts address phases, serves byte/half/word
// accesses from an internal RAM, inserts WAIT_STATES wait cycles per data
// phase and returns a two-cycle ERROR response for the ERR_BASE/ERR_MASK
// window, illegal sizes (HSIZE>2) and misaligned accesses.
//
// Ports
//   HCLK     in   bus clock
//   HRESETN  in   asynchronous active-low reset
//   bus      slave modport of bfm_ahbl_slave_if (HSEL..HWDATA, HREADY in;
//            HREADYOUT, HRESP, HRDATA, PROTERR out)
//
// Parameters
//   MEM_AW       RAM depth 2**MEM_AW words, indexed by HADDR[MEM_AW+1:2]
//                (higher address bits alias)
//   WAIT_STATES  0..15 wait cycles in every data phase
//   ERR_BASE/ERR_MASK  ERROR window, hit when (HADDR & ERR_MASK) == ERR_BASE
//   TPD          output delay for timing-annotated benches; outputs here are
//                decoded straight from registered state and carry no delay
//
// Build option
//   BFM_AHBL_SLAVE_PROTCHK_EN  compiles the protocol checker that drives the
//   sticky PROTERR flag and reports each violation cause; otherwise PROTERR
//   is tied low.
// ---------------------------------------------------------------------------
module bfm_ahbl_slave
    import bfm_ahbl_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_0000,
    parameter logic [31:0] ERR_MASK    = 32'hFFFF_0000,
    parameter int          TPD         = 1
) (
    input  logic             HCLK,
    input  logic             HRESETN,
    bfm_ahbl_slave_if.slave  bus
);

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [3:0]          wcnt_q;
    logic [MEM_AW+1:0]   addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic                err_q;

    logic                accept;
    logic                err_now;
    logic                load;
    logic                hreadyout;
    logic                hresp;
    logic [3:0]          ram_we;
    logic [31:0]         ram_rdata;

    // Sideband inputs this responder ignores, and the delay parameter.
    logic                unused_sideband;
    logic [31:0]         unused_tpd;
    assign unused_sideband = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};
    assign unused_tpd      = 32'(TPD);

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // The error cause is fixed at acceptance and travels with the transfer.
    assign err_now = ((bus.HADDR & ERR_MASK) == ERR_BASE)
                   | (bus.HSIZE > HSIZE_WORD)
                   | ((bus.HSIZE == HSIZE_HALF) & bus.HADDR[0])
                   | ((bus.HSIZE == HSIZE_WORD) & (bus.HADDR[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            // Every ready cycle (IDLE, last data cycle, second error cycle)
            // can take the next address phase.
            ST_IDLE, ST_DATA, ST_ERR2: begin
                hresp = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                if (accept) begin
                    load = 1'b1;
                    if (WAIT_STATES > 0) state_d = ST_WAIT;
                    else                 state_d = err_now ? ST_ERR1 : ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (wcnt_q == 4'd1) state_d = err_q ? ST_ERR1 : ST_DATA;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q  <= bus.HADDR[MEM_AW+1:0];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
                err_q   <= err_now;
                wcnt_q  <= WS4;
            end else if (state_q == ST_WAIT) begin
                wcnt_q  <= wcnt_q - 4'd1;
            end
        end
    end

    // Writes commit on the edge that closes the DATA cycle; an error never
    // reaches DATA, so it never writes.
    assign ram_we = (state_q == ST_DATA && write_q) ? be_of(size_q, addr_q[1:0]) : 4'b0000;

    bfm_ahbl_slave_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .idx   (addr_q[MEM_AW+1:2]),
        .wdata (bus.HWDATA),
        .rdata (ram_rdata)
    );

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? ram_rdata : 32'h0;

`ifdef BFM_AHBL_SLAVE_PROTCHK_EN
    // Previous-cycle view of the address bus, used to spot an address phase
    // that was presented while stalled and then changed before acceptance.
    logic        proterr_q;
    logic        stall_q;
    logic        prev_idle_q;
    logic [31:0] p_addr_q;
    logic        p_write_q;
    logic [2:0]  p_size_q;
    logic [1:0]  p_trans_q;
    logic        seq_after_idle;
    logic        hold_viol;
    logic        x_viol;

    assign seq_after_idle = bus.HSEL & (bus.HTRANS == HTRANS_SEQ) & prev_idle_q;
    assign hold_viol = stall_q & ((bus.HADDR  != p_addr_q)  | (bus.HWRITE != p_write_q) |
                                  (bus.HSIZE  != p_size_q)  | (bus.HTRANS != p_trans_q));
    assign x_viol = bus.HSEL & ($isunknown(bus.HTRANS) | $isunknown(bus.HADDR));

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            proterr_q   <= 1'b0;
            stall_q     <= 1'b0;
            prev_idle_q <= 1'b0;
            p_addr_q    <= 32'h0;
            p_write_q   <= 1'b0;
            p_size_q    <= 3'd0;
            p_trans_q   <= HTRANS_IDLE;
        end else begin
            stall_q   <= bus.HSEL & bus.HTRANS[1] & ~bus.HREADY;
            p_addr_q  <= bus.HADDR;
            p_write_q <= bus.HWRITE;
            p_size_q  <= bus.HSIZE;
            p_trans_q <= bus.HTRANS;
            if (bus.HSEL & bus.HREADY) prev_idle_q <= (bus.HTRANS == HTRANS_IDLE);
            if (seq_after_idle | hold_viol | x_viol) proterr_q <= 1'b1;
            if (seq_after_idle) $display("bfm_ahbl_slave: protocol violation: SEQ after IDLE");
            if (hold_viol)      $display("bfm_ahbl_slave: protocol violation: address phase changed while HREADY=0");
            if (x_viol)         $display("bfm_ahbl_slave: protocol violation: X on HTRANS/HADDR with HSEL=1");
        end
    end

    assign bus.PROTERR = proterr_q;
`else
    assign bus.PROTERR = 1'b0;
`endif

endmodule

// File: tb/tb_bfm_ahbl_slave.sv
// ---------------------------------------------------------------------------
// tb_bfm_ahbl_slave
// Two responders on one set of master signals: dut0 with no wait states,
// dut1 with three. dsel picks which one sees HSEL. A pipelined master task
// runs short transfer lists; every completed transfer is scored against a
// word-array model of each RAM using the response/latency rules.
// ---------------------------------------------------------------------------
module tb_bfm_ahbl_slave;
    import bfm_ahbl_pkg::*;

`ifdef BFM_AHBL_SLAVE_PROTCHK_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESETN = 1'b0;
    always #5 HCLK = ~HCLK;

    bfm_ahbl_slave_if bus0();
    bfm_ahbl_slave_if bus1();

    logic        dsel;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;

    assign bus0.HSEL = hsel & ~dsel;
    assign bus1.HSEL = hsel & dsel;
    assign bus0.HADDR = haddr;    assign bus1.HADDR = haddr;
    assign bus0.HWRITE = hwrite;  assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;    assign bus1.HSIZE = hsize;
    assign bus0.HTRANS = htrans;  assign bus1.HTRANS = htrans;
    assign bus0.HWDATA = hwdata;  assign bus1.HWDATA = hwdata;
    assign bus0.HBURST = 3'd0;    assign bus1.HBURST = 3'd0;
    assign bus0.HPROT = 4'h3;     assign bus1.HPROT = 4'h3;
    assign bus0.HMASTLOCK = 1'b0; assign bus1.HMASTLOCK = 1'b0;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    logic        hready, hresp, proterr;
    logic [31:0] hrdata;
    assign hready  = dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign hresp   = dsel ? bus1.HRESP     : bus0.HRESP;
    assign hrdata  = dsel ? bus1.HRDATA    : bus0.HRDATA;
    assign proterr = dsel ? bus1.PROTERR   : bus0.PROTERR;

    bfm_ahbl_slave #(.MEM_AW(10), .WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(bus0));
    bfm_ahbl_slave #(.MEM_AW(10), .WAIT_STATES(3)) dut1 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl [2][1024];

    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
        return ((a & 32'hFFFF_0000) == 32'hFFFF_0000) || (s > 3'd2) ||
               (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [2:0] s);
        int nb = 1 << s;
        int off = int'(a[1:0]);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + nb) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- transfer lists ----------------
    logic [31:0] t_addr [8];
    logic [31:0] t_wdata[8];
    logic        t_wr   [8];
    logic [2:0]  t_size [8];
    logic [31:0] r_rdata[8];
    logic        r_resp [8];
    int          r_lat  [8];
    int          r_waits[8];
    int          r_err1 [8];
    int          r_zbad [8];

    task automatic set_t(input int i, input logic [31:0] a, input logic w,
                         input logic [2:0] s, input logic [31:0] d);
        t_addr[i] = a; t_wr[i] = w; t_size[i] = s; t_wdata[i] = d;
    endtask

    task automatic rand_t(input int i);
        int idx = $urandom_range(0, 63);
        logic [2:0] s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        logic [31:0] a;
        int lo = $urandom_range(0, 3);
        if ($urandom_range(0, 4) != 0) lo = lo & ~((1 << s) - 1);
        a = 32'(idx * 4 + lo);
        if ($urandom_range(0, 7) == 0)      a = a | 32'hFFFF_0000;
        else if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
        set_t(i, a, 1'($urandom_range(0, 1)), s, $urandom);
    endtask

    task automatic score(input int i);
        int ws = dsel ? 3 : 0;
        bit e = exp_err(t_addr[i], t_size[i]);
        int idx = int'(t_addr[i][11:2]);
        tb_check("resp",  32'(r_resp[i]), 32'(e));
        tb_check("lat",   r_lat[i], ws + 1 + int'(e));
        tb_check("waits", r_waits[i], ws);
        tb_check("err1",  r_err1[i], int'(e));
        tb_check("rdz",   r_zbad[i], 0);
        if (!t_wr[i] && !e) tb_check("rdata", r_rdata[i], mdl[dsel][idx]);
        else                tb_check("rdata0", r_rdata[i], 32'h0);
        if (t_wr[i] && !e) mdl[dsel][idx] = merge(mdl[dsel][idx], t_wdata[i], t_addr[i], t_size[i]);
    endtask

    task automatic drive_addr(input int i);
        hsel = 1'b1; haddr = t_addr[i]; hwrite = t_wr[i]; hsize = t_size[i]; htrans = HTRANS_NONSEQ;
    endtask

    // Pipelined master: called at posedge+1; the next address phase is only
    // changed after an edge on which HREADY was high.
    task automatic run(input int n);
        int nxt = 1, pres = 0, dat = -1, done = 0, guard = 0;
        logic rdy_prev;
        for (int i = 0; i < n; i++) begin
            r_lat[i] = 0; r_waits[i] = 0; r_err1[i] = 0; r_zbad[i] = 0;
        end
        drive_addr(0);
        rdy_prev = hready;
        while (done < n) begin
            @(posedge HCLK); #1;
            if (rdy_prev) begin
                dat = pres; pres = -1;
                if (nxt < n) begin drive_addr(nxt); pres = nxt; nxt++; end
                else htrans = HTRANS_IDLE;
                if (dat >= 0) hwdata = t_wdata[dat];
            end
            rdy_prev = hready;
            if (dat >= 0) begin
                r_lat[dat]++;
                if (!hready) begin
                    if (hresp) r_err1[dat]++; else r_waits[dat]++;
                    if (hrdata != 32'h0) r_zbad[dat]++;
                end else begin
                    r_rdata[dat] = hrdata; r_resp[dat] = hresp;
                    score(dat);
                    done++; dat = -1;
                end
            end
            guard++;
            if (guard > 200) begin tb_check("timeout", 1, 0); break; end
        end
    endtask

    task automatic idle_cycles(input int n);
        htrans = HTRANS_IDLE;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        tb_check({tag, ".rdy0"}, 32'(bus0.HREADYOUT), 1);
        tb_check({tag, ".resp0"}, 32'(bus0.HRESP), 0);
        tb_check({tag, ".rd0"}, bus0.HRDATA, 0);
        tb_check({tag, ".perr0"}, 32'(bus0.PROTERR), 0);
        tb_check({tag, ".rdy1"}, 32'(bus1.HREADYOUT), 1);
        tb_check({tag, ".resp1"}, 32'(bus1.HRESP), 0);
        tb_check({tag, ".rd1"}, bus1.HRDATA, 0);
        tb_check({tag, ".perr1"}, 32'(bus1.PROTERR), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 1024; w++) mdl[d][w] = 32'h0;
        dsel = 1'b0; hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
        htrans = HTRANS_IDLE; hwdata = 32'h0;
        repeat (2) @(posedge HCLK); #1;
        check_reset_vals("reset");
        @(negedge HCLK) HRESETN = 1'b1;
        @(posedge HCLK); #1;

        // Known contents for word indices 0..63 in both RAMs.
        for (int d = 0; d < 2; d++) begin
            dsel = 1'(d);
            for (int k = 0; k < 64; k += 4) begin
                for (int j = 0; j < 4; j++) set_t(j, 32'((k + j) * 4), 1'b1, 3'd2, $urandom);
                run(4);
            end
        end

        // Zero wait states: write then read back, pipelined.
        dsel = 1'b0;
        set_t(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        set_t(1, 32'h10, 1'b0, 3'd2, 32'h0);
        run(2);
        tb_check("t1_rd", r_rdata[1], 32'hDEADBEEF);
        tb_check("t1_stall", 32'(r_waits[0] + r_waits[1]), 0);

        // Three wait states on a word read.
        dsel = 1'b1;
        set_t(0, 32'h20, 1'b1, 3'd2, 32'hA5A5_0020); run(1);
        set_t(0, 32'h20, 1'b0, 3'd2, 32'h0);         run(1);
        tb_check("t2_waits", r_waits[0], 3);
        tb_check("t2_rd", r_rdata[0], 32'hA5A5_0020);
        tb_check("t2_resp", 32'(r_resp[0]), 0);

        // Byte lane merge.
        dsel = 1'b0;
        set_t(0, 32'h40, 1'b1, 3'd2, 32'h1122_3344);
        set_t(1, 32'h41, 1'b1, 3'd0, 32'h0000_AA00);
        set_t(2, 32'h40, 1'b0, 3'd2, 32'h0);
        run(3);
        tb_check("t3_rd", r_rdata[2], 32'h1122_AA44);

        // ERROR window; NONSEQ presented during the error completes in ERR2.
        set_t(0, 32'h4, 1'b1, 3'd2, 32'h0123_4567);
        set_t(1, 32'h8, 1'b1, 3'd2, 32'h89AB_CDEF);
        run(2);
        set_t(0, 32'hFFFF_0004, 1'b0, 3'd2, 32'h0);
        set_t(1, 32'h4,         1'b0, 3'd2, 32'h0);
        set_t(2, 32'hFFFF_0008, 1'b1, 3'd2, 32'hBAD0_BAD0);
        set_t(3, 32'h8,         1'b0, 3'd2, 32'h0);
        run(4);
        tb_check("t4_err", 32'(r_resp[0]), 1);
        tb_check("t4_err1", r_err1[0], 1);
        tb_check("t4_ok", 32'(r_resp[1]), 0);
        tb_check("t4_rd", r_rdata[1], 32'h0123_4567);
        tb_check("t4_keep", r_rdata[3], 32'h89AB_CDEF);

        // Misaligned word and illegal size, then address aliasing.
        set_t(0, 32'h100, 1'b1, 3'd2, 32'h5566_7788); run(1);
        set_t(0, 32'h102, 1'b1, 3'd2, 32'hFFFF_FFFF);
        set_t(1, 32'h100, 1'b1, 3'd3, 32'hFFFF_FFFF);
        set_t(2, 32'h100, 1'b0, 3'd2, 32'h0);
        run(3);
        tb_check("t5_mis", 32'(r_resp[0]), 1);
        tb_check("t5_size", 32'(r_resp[1]), 1);
        tb_check("t5_keep", r_rdata[2], 32'h5566_7788);
        set_t(0, 32'h1000, 1'b1, 3'd2, 32'h5A5A_1234);
        set_t(1, 32'h0,    1'b0, 3'd2, 32'h0);
        run(2);
        tb_check("t5_alias", r_rdata[1], 32'h5A5A_1234);

        // Random traffic on both responders.
        for (int d = 0; d < 2; d++) begin
            dsel = 1'(d);
            for (int r = 0; r < 20; r++) begin
                int n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) rand_t(i);
                run(n);
            end
        end

        // Address phase changed while stalled.
        dsel = 1'b1;
        idle_cycles(2);
        hsel = 1'b1; haddr = 32'h20; hwrite = 1'b0; hsize = 3'd2; htrans = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        tb_check("pc_wait", 32'(hready), 0);
        haddr = 32'h24;
        @(posedge HCLK); #1;
        haddr = 32'h28;
        @(posedge HCLK); #1;
        htrans = HTRANS_IDLE;
        guard = 0;
        while (!hready && guard < 20) begin @(posedge HCLK); #1; guard++; end
        tb_check("pc_done", 32'(guard < 20), 1);
        @(posedge HCLK); #1;
        tb_check("proterr", 32'(proterr), 32'(PC_EN));

        // Reset during the wait states of a write discards it.
        set_t(0, 32'h30, 1'b1, 3'd2, 32'h1357_9BDF); run(1);
        idle_cycles(2);
        haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF;
        tb_check("rst_inwait", 32'(hready), 0);
        HRESETN = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESETN = 1'b1;
        @(posedge HCLK); #1;
        set_t(0, 32'h30, 1'b0, 3'd2, 32'h0); run(1);
        tb_check("rst_old", r_rdata[0], 32'h1357_9BDF);

        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
